// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and FSM encoding for the interrupt pending arbiter
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// rtl/irq_pending_arbiter_if.sv - offer handshake and pending-vector bundle
interface irq_pending_arbiter_if;
    import irq_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [N_REQ-1:0] pending;

    modport master (
        output out_valid,
        output out_idx,
        output pending,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  pending,
        output out_ready
    );

endinterface

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - combinational 8-to-3 encoder, highest set bit wins
module priority_encoder
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx
);

    // Ascending scan so the last (highest) set bit overrides; zero input yields 0, never consumed.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - pending capture, masking and stable-offer arbitration (IRQ_EDGE_DETECT_EN selects edge capture)
module irq_pending_arbiter
    import irq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ-1:0]       mask,
    irq_pending_arbiter_if.master  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_out_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] w_set;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_eligible;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_handshake;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N_REQ-1:0] r_req_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= req_in;
        end
    end

    assign w_set = req_in & ~r_req_q;
`else
    assign w_set = req_in;
`endif

    assign w_handshake = (r_state == OFFER) && bus.out_ready;
    assign w_clr       = w_handshake ? ({{(N_REQ-1){1'b0}}, 1'b1} << r_out_idx) : '0;

    // Set is OR-ed after the clear so an event arriving on the granted bit survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    assign w_eligible = r_pending & mask;

    priority_encoder u_priority_encoder (
        .i_vec (w_eligible),
        .o_idx (w_enc_idx)
    );

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_out_idx;
        case (r_state)
            IDLE: begin
                if (|w_eligible) begin
                    w_state_next = OFFER;
                    w_idx_next   = w_enc_idx;
                end
            end
            OFFER: begin
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_out_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_out_idx <= w_idx_next;
        end
    end

    assign bus.out_valid = (r_state == OFFER);
    assign bus.out_idx   = r_out_idx;
    assign bus.pending   = r_pending;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - directed and randomized self-checking bench for irq_pending_arbiter
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;

    int errors = 0;
    int checks = 0;

    irq_pending_arbiter_if ifc ();

    irq_pending_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .mask   (mask),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    // Reference state: pending flags, the current offer, and last-seen request levels.
    bit m_pend [8];
    bit m_prev [8];
    bit m_valid;
    int m_idx;

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit nxt [8];
        bit grant;
        int best;
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 0;
            end
            m_valid = 0;
            m_idx   = 0;
            return;
        end
        grant = m_valid && (ifc.out_ready === 1'b1);
        for (int i = 0; i < 8; i++) begin
            bit ev;
`ifdef IRQ_EDGE_DETECT_EN
            ev = req_in[i] && !m_prev[i];
`else
            ev = req_in[i];
`endif
            nxt[i] = (m_pend[i] && !(grant && i == m_idx)) || ev;
        end
        if (m_valid) begin
            if (grant) m_valid = 0;
        end else begin
            best = -1;
            for (int i = 7; i >= 0 && best < 0; i--) begin
                if (m_pend[i] && mask[i]) best = i;
            end
            if (best >= 0) begin
                m_valid = 1;
                m_idx   = best;
            end
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = nxt[i];
            m_prev[i] = req_in[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("mdl_valid", 32'(ifc.out_valid), 32'(m_valid));
        check("mdl_idx", 32'(ifc.out_idx), 32'(m_idx));
        check("mdl_pending", 32'(ifc.pending), 32'(m_pend_vec()));
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_in = 8'h00;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int g_idx [$];
        int g_cyc [$];
        int exp_prio [3] = '{5, 2, 0};
        int held_grants;
        int held_exp;

        for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
        end
        m_valid = 0;
        m_idx   = 0;

        // Reset with all requests high
        rst_n  = 1'b0;
        req_in = 8'hFF;
        mask   = 8'hFF;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        check("rst_pending", 32'(ifc.pending), 32'h00);
        check("rst_valid", 32'(ifc.out_valid), 32'h0);
        check("rst_idx", 32'(ifc.out_idx), 32'h0);
        rst_n = 1'b1;
        tick();
        check("rel_valid_early", 32'(ifc.out_valid), 32'h0);
        tick();
        check("rel_valid", 32'(ifc.out_valid), 32'h1);
        check("rel_idx", 32'(ifc.out_idx), 32'h7);

        // Priority order with ready held
        do_reset();
        mask = 8'hFF;
        ifc.out_ready = 1'b1;
        req_in = 8'b0010_0101;
        tick();
        req_in = 8'h00;
        for (int c = 0; c < 20; c++) begin
            if (ifc.out_valid && ifc.out_ready) begin
                g_idx.push_back(int'(ifc.out_idx));
                g_cyc.push_back(c);
            end
            tick();
        end
        check("prio_count", 32'(g_idx.size()), 32'd3);
        for (int k = 0; k < g_idx.size() && k < 3; k++) begin
            check("prio_order", 32'(g_idx[k]), 32'(exp_prio[k]));
            if (k > 0) check("prio_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'd2);
        end
        check("prio_pending_end", 32'(ifc.pending), 32'h00);

        // Mask holds bit 7 pending but ineligible
        do_reset();
        mask = 8'h7F;
        req_in = 8'b1000_0010;
        tick();
        req_in = 8'h00;
        tick();
        check("mask_valid", 32'(ifc.out_valid), 32'h1);
        check("mask_idx", 32'(ifc.out_idx), 32'h1);
        check("mask_pend7", 32'(ifc.pending[7]), 32'h1);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        tick();
        check("mask_idle", 32'(ifc.out_valid), 32'h0);
        check("mask_pend_kept", 32'(ifc.pending), 32'h80);
        mask = 8'hFF;
        tick();
        check("unmask_valid", 32'(ifc.out_valid), 32'h1);
        check("unmask_idx", 32'(ifc.out_idx), 32'h7);

        // Offer stays stable while a higher request arrives
        do_reset();
        mask = 8'hFF;
        req_in = 8'h04;
        tick();
        req_in = 8'h00;
        tick();
        check("stable_idx0", 32'(ifc.out_idx), 32'h2);
        req_in = 8'h40;
        tick();
        req_in = 8'h00;
        for (int k = 0; k < 3; k++) begin
            check("stable_valid", 32'(ifc.out_valid), 32'h1);
            check("stable_idx", 32'(ifc.out_idx), 32'h2);
            tick();
        end
        ifc.out_ready = 1'b1;
        tick();
        check("stable_hs_drop", 32'(ifc.out_valid), 32'h0);
        ifc.out_ready = 1'b0;
        tick();
        check("stable_next_idx", 32'(ifc.out_idx), 32'h6);
        check("stable_next_valid", 32'(ifc.out_valid), 32'h1);

        // Set-versus-clear collision on the granted bit
        do_reset();
        mask = 8'hFF;
        req_in = 8'h08;
        tick();
        req_in = 8'h00;
        tick();
        check("coll_idx", 32'(ifc.out_idx), 32'h3);
        ifc.out_ready = 1'b1;
        req_in = 8'h08;
        tick();
        check("coll_pend3", 32'(ifc.pending[3]), 32'h1);
        check("coll_valid_low", 32'(ifc.out_valid), 32'h0);
        ifc.out_ready = 1'b0;
        tick();
        check("coll_reoffer_valid", 32'(ifc.out_valid), 32'h1);
        check("coll_reoffer_idx", 32'(ifc.out_idx), 32'h3);
        req_in = 8'h00;

        // Held line
        do_reset();
        mask = 8'hFF;
        ifc.out_ready = 1'b1;
        req_in = 8'h10;
        held_grants = 0;
        for (int k = 0; k < 12; k++) begin
            if (ifc.out_valid) begin
                held_grants++;
                check("held_idx", 32'(ifc.out_idx), 32'h4);
            end
            tick();
        end
`ifdef IRQ_EDGE_DETECT_EN
        held_exp = 1;
`else
        held_exp = 5;
`endif
        check("held_grants", 32'(held_grants), 32'(held_exp));
        req_in = 8'h00;

        // Randomized traffic against the reference model, including mid-offer resets
        do_reset();
        for (int k = 0; k < 500; k++) begin
            rst_n  = ($urandom_range(0, 63) != 0);
            req_in = 8'($urandom) & 8'($urandom);
            mask   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ifc.out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
